// File: rtl/data_mem_resp.sv
// data_mem_resp: word-array data memory with wait states, byte lanes and error responses.
module data_mem_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic        memwrite,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state;
  logic [2:0]            cnt;
  logic [31:0]           a_q, d_q;
  logic [3:0]            s_q;
  logic                  w_q, bad, acc;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           mem [2**ADDR_WIDTH];
  assign idx = a_q[ADDR_WIDTH+1:2];
  assign acc = memen && state != WAIT;
  assign bad = !((s_q == 4'hf && a_q[1:0] == 2'b00) ||
                 ((s_q == 4'h3 || s_q == 4'hc) && !a_q[0]) ||
                 (s_q inside {4'h1, 4'h2, 4'h4, 4'h8})) ||
               ((a_q >> (ADDR_WIDTH + 2)) != 32'd0);
  // The captured request completes on the edge that leaves RESP; ready is visible the cycle after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
      a_q   <= 32'd0;
      d_q   <= 32'd0;
      s_q   <= 4'd0;
      w_q   <= 1'b0;
    end else begin
      ready <= state == RESP;
      if (state == RESP) begin
        err   <= bad;
        rdata <= bad ? 32'd0 : w_q ? rdata : mem[idx];
      end
      if (acc) begin
        a_q   <= addr;
        d_q   <= wdata;
        s_q   <= sel;
        w_q   <= memwrite;
        state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt   <= WAIT_CYCLES == 0 ? 3'd0 : 3'(WAIT_CYCLES - 1);
      end else if (state == WAIT) begin
        cnt   <= cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
        state <= cnt == 3'd0 ? RESP : WAIT;
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == RESP && w_q && !bad)
      for (int i = 0; i < 4; i++)
        if (s_q[i]) mem[idx][8*i +: 8] <= d_q[8*i +: 8];
  end
endmodule
